// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the fetch PC, keeps at most one imem read in flight and
// buffers returned words with their PC in a small FIFO feeding decode.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_DROP
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [31:0]     instr_mem_q [DEPTH];
   logic [31:0]     pc_mem_q    [DEPTH];
   logic            push, pop, req_fire;

   assign imem_req_addr  = pc_q;
   // A slot is reserved at issue time, so a returning response always fits.
   assign imem_req_valid = !reset && (state_q == ST_REQ) && (count_q < FULL_CNT) && !redirect_valid;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign out_valid    = (count_q != '0);
   assign out_instr    = out_valid ? instr_mem_q[rd_ptr_q]   : '0;
   assign out_pc       = out_valid ? pc_mem_q[rd_ptr_q]      : '0;
   assign out_pc_plus4 = out_valid ? pc_mem_q[rd_ptr_q] + 32'd4 : '0;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      push     = 1'b0;
      pop      = 1'b0;

      if (redirect_valid) begin
         pc_d     = redirect_pc & 32'hFFFF_FFFC;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         unique case (state_q)
            ST_WAIT: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
            ST_DROP: state_d = imem_resp_valid ? ST_REQ : ST_DROP;
            default: state_d = ST_REQ;
         endcase
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (req_fire) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + 32'd4;
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_resp_valid) begin
                  push    = 1'b1;
                  state_d = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem_resp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
         endcase

         pop = out_valid && out_ready;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= imem_resp_data;
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction-memory model with programmable latency
// returns addr ^ 32'hA5A5_0000; outputs are checked at the falling edge.
module tb_fetch_unit;

   localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int          checks = 0;
   int          errors = 0;

   // memory model state
   int          lat = 1;
   bit          mem_busy = 0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   int          fire_count = 0;
   logic [31:0] fire_log [$];

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_pc_plus4    (out_pc_plus4),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   // One clock cycle: starts just after a falling edge, ends on the next falling edge.
   task automatic cycle();
      bit          resp_now;
      bit          fire_now;
      logic [31:0] fire_addr;
      resp_now = mem_busy && (mem_cnt == 0);
      imem_resp_valid = resp_now;
      imem_resp_data  = resp_now ? (mem_addr ^ XOR_PAT) : 32'h0;
      #1;
      fire_now  = imem_req_valid && imem_req_ready;
      fire_addr = imem_req_addr;
      @(posedge clk);
      if (resp_now) mem_busy = 0;
      if (reset) begin
         mem_busy = 0;
      end else if (fire_now) begin
         mem_busy = 1;
         mem_addr = fire_addr;
         mem_cnt  = lat - 1;
         fire_count++;
         fire_log.push_back(fire_addr);
      end else if (mem_busy && mem_cnt > 0) begin
         mem_cnt--;
      end
      @(negedge clk);
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
   endtask

   task automatic check_out(input string tag, input logic [31:0] pc);
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_pc"}, out_pc, pc);
      check({tag, "_instr"}, out_instr, pc ^ XOR_PAT);
      check({tag, "_pc4"}, out_pc_plus4, pc + 32'd4);
   endtask

   task automatic check_req(input string tag, input logic v, input logic [31:0] addr);
      check({tag, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
      if (v) check({tag, "_req_addr"}, imem_req_addr, addr);
   endtask

   initial begin
      reset           = 1'b1;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      out_ready       = 1'b1;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;

      // ---- reset ----
      @(negedge clk);
      settle();
      check("rst_req_valid_pre", {31'b0, imem_req_valid}, 32'd0);
      cycle();
      settle();
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_pc4", out_pc_plus4, 32'd0);
      reset = 1'b0;
      settle();

      // ---- 1-cycle memory, streaming ----
      check_req("t1c0", 1'b1, 32'h0);
      check("t1c0_out_valid", {31'b0, out_valid}, 32'd0);
      cycle(); settle();
      check_req("t1c1", 1'b0, 32'h0);
      cycle(); settle();
      check_out("t1c2", 32'h0);
      check_req("t1c2", 1'b1, 32'h4);
      cycle(); settle();
      check("t1c3_out_valid", {31'b0, out_valid}, 32'd0);
      check_req("t1c3", 1'b0, 32'h0);
      cycle(); settle();
      check_out("t1c4", 32'h4);
      check_req("t1c4", 1'b1, 32'h8);
      cycle(); cycle(); settle();
      check_out("t1c6", 32'h8);
      check_req("t1c6", 1'b1, 32'hC);
      cycle(); cycle(); settle();
      check_out("t1c8", 32'hC);
      check("t1_fires", fire_count, 4);
      check("t1_fire3", fire_log[3], 32'hC);

      // ---- back-pressure: FIFO fills, requests stop ----
      reset = 1'b1;
      settle();
      check_req("t2rst", 1'b0, 32'h0);
      cycle();
      reset      = 1'b0;
      out_ready  = 1'b0;
      fire_count = 0;
      fire_log.delete();
      settle();
      for (int i = 0; i < 10; i++) begin
         if (i >= 2) check("t2_hold_pc", out_pc, 32'h0);
         cycle();
         settle();
      end
      check("t2_fires", fire_count, 2);
      check("t2_fire0", fire_log[0], 32'h0);
      check("t2_fire1", fire_log[1], 32'h4);
      check_req("t2full", 1'b0, 32'h0);
      check_out("t2e0", 32'h0);
      out_ready = 1'b1;
      settle();
      cycle(); settle();
      check_out("t2e1", 32'h4);
      check_req("t2e1", 1'b1, 32'h8);
      lat = 3;

      // ---- redirect during WAIT, late response dropped ----
      cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      settle();
      check("t3_out_valid_e2", {31'b0, out_valid}, 32'd0);
      check_req("t3e2", 1'b0, 32'h0);
      cycle();
      redirect_valid = 1'b0;
      settle();
      check_req("t3e3", 1'b0, 32'h0);
      check("t3e3_out_valid", {31'b0, out_valid}, 32'd0);
      cycle(); settle();
      check_req("t3e4", 1'b0, 32'h0);
      check("t3e4_resp_due", {31'b0, mem_busy}, 32'd1);
      cycle(); settle();
      check("t3e5_out_valid", {31'b0, out_valid}, 32'd0);
      check_req("t3e5", 1'b1, 32'h100);
      lat = 1;
      cycle(); settle();
      check("t3e6_out_valid", {31'b0, out_valid}, 32'd0);
      cycle();
      out_ready = 1'b0;
      settle();
      check_out("t3e7", 32'h100);
      check_req("t3e7", 1'b1, 32'h104);

      // ---- redirect together with response and pop ----
      cycle();
      out_ready      = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      settle();
      check_out("t4e8", 32'h100);
      cycle();
      redirect_valid = 1'b0;
      settle();
      check("t4_out_valid", {31'b0, out_valid}, 32'd0);
      check("t4_out_pc", out_pc, 32'd0);
      check("t4_out_instr", out_instr, 32'd0);
      check_req("t4e9", 1'b1, 32'h200);
      cycle(); cycle(); settle();
      check_out("t4e11", 32'h200);

      // ---- PC wrap via redirect from REQ ----
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      settle();
      check_req("t5_redir", 1'b0, 32'h0);
      cycle();
      redirect_valid = 1'b0;
      settle();
      check("t5_out_valid", {31'b0, out_valid}, 32'd0);
      check_req("t5f0", 1'b1, 32'hFFFF_FFFC);
      cycle(); cycle(); settle();
      check("t5_pc", out_pc, 32'hFFFF_FFFC);
      check("t5_instr", out_instr, 32'h5A5A_FFFC);
      check("t5_pc4", out_pc_plus4, 32'h0000_0000);
      check_req("t5f2", 1'b1, 32'h0);
      cycle(); cycle(); settle();
      check_out("t5f4", 32'h0);

      // ---- reset mid-flight with buffered data ----
      lat       = 3;
      out_ready = 1'b0;
      cycle();
      reset = 1'b1;
      settle();
      check_out("t6f5", 32'h0);
      check_req("t6f5", 1'b0, 32'h0);
      cycle();
      reset = 1'b0;
      lat   = 1;
      settle();
      check("t6_out_valid", {31'b0, out_valid}, 32'd0);
      check_req("t6f6", 1'b1, 32'h0);
      cycle(); cycle(); settle();
      check_out("t6f8", 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
